// File: rtl/adder_axi_master.sv
// ---------------------------------------------------------------------------
// adder_axi_master
//   AXI4-Lite initiator that turns single read/write commands from a simple
//   valid/ready command port into one complete AXI4-Lite transaction each.
//   One transaction outstanding at a time and no bursts. Completion is
//   reported on a one-cycle response strobe carrying read data and the
//   BRESP/RRESP code.
//
//   Optional feature macro: ADDER_AXI_MASTER_TIMEOUT_EN
//     Defined   : 16-bit watchdog counts cycles spent outside IDLE and sets
//                 the sticky o_timeout flag on reaching C_TIMEOUT_CYCLES.
//     Undefined : no watchdog, o_timeout is constant 0.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake (ready = block idle)
//   i_cmd_write                 1 = write, 0 = read
//   i_cmd_addr/data/strb        command payload, latched on accept
//   o_rsp_valid                 one-cycle completion strobe
//   o_rsp_data                  read data (0 after a write completion)
//   o_rsp_resp                  BRESP/RRESP of the completed transaction
//   o_timeout                   sticky watchdog flag
//   M_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite master channels
// ---------------------------------------------------------------------------
module adder_axi_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_strb,

    output logic                            o_rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]                      o_rsp_resp,
    output logic                            o_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t                          state_q,     state_d;
    logic                            awvalid_q,   awvalid_d;
    logic                            wvalid_q,    wvalid_d;
    logic                            bready_q,    bready_d;
    logic                            arvalid_q,   arvalid_d;
    logic                            rready_q,    rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q,      data_d;
    logic [STRB_W-1:0]               strb_q,      strb_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic [1:0]                      rsp_resp_q,  rsp_resp_d;

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    addr_d = i_cmd_addr;
                    data_d = i_cmd_data;
                    strb_d = i_cmd_strb;
                    if (i_cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WR_REQ: begin
                // AW and W retire independently; a dropped VALID marks its
                // channel as done, so the phase ends once both are low.
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end

            WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_data_d  = '0;
                end
            end

            RD_REQ: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_data_d  = M_AXI_RDATA;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_cmd_ready   = (state_q == IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_resp    = rsp_resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(C_TIMEOUT_CYCLES);

    logic [15:0] wdog_q,    wdog_d;
    logic        timeout_q, timeout_d;

    // Counting on the next state makes the register equal the number of
    // non-IDLE cycles including the current one, so the flag rises in the
    // C_TIMEOUT_CYCLES-th cycle after the accept edge.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (state_d == IDLE) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_LIMIT) begin
            wdog_d = wdog_q + 16'd1;
        end
        if ((state_d != IDLE) && (wdog_d == WDOG_LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    // Watchdog not built; the limit parameter stays on the interface for
    // drop-in compatibility and folds to a constant 0 here.
    assign o_timeout = 1'b0 & (C_TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_adder_axi_master.sv
module tb_adder_axi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        timeout;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    always #5 clk = ~clk;

    adder_axi_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_TIMEOUT_CYCLES   (16)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_data    (cmd_data),
        .i_cmd_strb    (cmd_strb),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_rsp_resp    (rsp_resp),
        .o_timeout     (timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // ---------------- slave with programmable wait states ----------------
    int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          b_never = 1'b0;
    logic [1:0]  s_bresp = '0, s_rresp = '0;
    logic [31:0] s_rdata = '0;

    int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_seen, w_seen, b_pend, r_pend;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic        aw_done_now, w_done_now;

    assign awready     = awvalid && !aw_seen && (aw_cnt >= aw_dly);
    assign wready      = wvalid  && !w_seen  && (w_cnt  >= w_dly);
    assign arready     = arvalid && !r_pend  && (ar_cnt >= ar_dly);
    assign bvalid      = b_pend && !b_never && (b_cnt >= b_dly);
    assign rvalid      = r_pend && (r_cnt >= r_dly);
    assign bresp       = s_bresp;
    assign rresp       = s_rresp;
    assign rdata       = s_rdata;
    assign aw_done_now = aw_seen || (awvalid && awready);
    assign w_done_now  = w_seen  || (wvalid  && wready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0; cap_araddr <= '0;
        end else begin
            if (bvalid && bready) begin
                b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
                aw_cnt <= 0; w_cnt <= 0;
            end else begin
                if (awvalid && awready) begin
                    aw_seen <= 1'b1; cap_awaddr <= awaddr;
                end else if (awvalid) begin
                    aw_cnt <= aw_cnt + 1;
                end
                if (wvalid && wready) begin
                    w_seen <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
                end else if (wvalid) begin
                    w_cnt <= w_cnt + 1;
                end
                if (aw_done_now && w_done_now && !b_pend) begin
                    b_pend <= 1'b1; b_cnt <= 0;
                end else if (b_pend && !bvalid) begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0; cap_araddr <= araddr;
            end else if (arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) begin
                r_pend <= 1'b0;
            end else if (r_pend && !rvalid) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    logic [31:0] last_rsp_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Issue one command and follow it cycle by cycle. Cycle k is the period
    // after the k-th rising edge counted from the accept edge (edge 0).
    task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int unsigned daw, input int unsigned dw,
                           input int unsigned db, input int unsigned dar, input int unsigned dr,
                           input logic [1:0] resp, input logic [31:0] rd);
        int unsigned rsp_cyc, t_wr;
        logic [6:0]  obs_v, exp_v;
        logic [31:0] exp_data;
        aw_dly = daw; w_dly = dw; b_dly = db; ar_dly = dar; r_dly = dr;
        s_bresp = resp; s_rresp = resp; s_rdata = rd;
        chk("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_data = $urandom; cmd_strb = 4'($urandom_range(0, 15));
        t_wr    = 1 + max2(daw, dw);
        rsp_cyc = wr ? (t_wr + 2 + db) : (3 + dar + dr);
        for (int unsigned k = 1; k <= rsp_cyc; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            obs_v = {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready};
            exp_v[6] = (k == rsp_cyc);
            exp_v[5] = (k == rsp_cyc);
            exp_v[4] = wr  && (k <= 1 + daw);
            exp_v[3] = wr  && (k <= 1 + dw);
            exp_v[2] = wr  && (k >= t_wr + 1) && (k < rsp_cyc);
            exp_v[1] = !wr && (k <= 1 + dar);
            exp_v[0] = !wr && (k >= 2 + dar) && (k < rsp_cyc);
            chk($sformatf("handshake_vec_k%0d", k), {57'd0, obs_v}, {57'd0, exp_v});
            if (exp_v[4]) chk("awaddr_stable", {32'd0, awaddr}, {32'd0, a});
            if (exp_v[3]) chk("wdata_wstrb_stable", {28'd0, wstrb, wdata}, {28'd0, s, d});
            if (exp_v[1]) chk("araddr_stable", {32'd0, araddr}, {32'd0, a});
            if (k < rsp_cyc) chk("rsp_data_hold", {32'd0, rsp_data}, {32'd0, last_rsp_data});
        end
        exp_data = wr ? 32'd0 : rd;
        chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_data});
        chk("rsp_resp", {62'd0, rsp_resp}, {62'd0, resp});
        if (wr) chk("slave_write_capture", {cap_wstrb, cap_awaddr, cap_wdata[27:0]}, {s, a, d[27:0]});
        else    chk("slave_read_capture", {32'd0, cap_araddr}, {32'd0, a});
        last_rsp_data = exp_data;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [1:0]  rresp_r;
        bit          wr_r;
        logic        exp_to;

        // Reset state
        #12;
        chk("reset_handshake_vec", {57'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 64'h40);
        chk("reset_rsp", {30'd0, timeout, rsp_resp, rsp_data}, 64'd0);
        chk("reset_payload", {wstrb, awaddr, wdata[27:0]}, 64'd0);
        chk("reset_araddr_prot", {26'd0, awprot, arprot, araddr}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write of 7 to address 0
        run_cmd(1'b1, 32'h0, 32'h7, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0);
        // Read of address 8 with RVALID delayed 4 cycles
        run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 4, 2'b00, 32'h0000_000C);
        // AWREADY delayed 3 cycles, WREADY immediate
        run_cmd(1'b1, 32'h4, 32'hA5A5_0001, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0);
        // WREADY delayed, AWREADY immediate, B delayed
        run_cmd(1'b1, 32'h10, 32'h1234_5678, 4'hC, 0, 2, 2, 0, 0, 2'b01, 32'h0);
        // SLVERR on write, then a read accepted in the response cycle
        run_cmd(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0);
        run_cmd(1'b0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b11, 32'hCAFE_F00D);
        chk("prot_zero", {58'd0, awprot, arprot}, 64'd0);

        // Reset while waiting in the read-response phase
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 10; s_rdata = 32'h55; s_rresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rready_before_abort", {63'd0, rready}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_handshake_vec", {57'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 64'h40);
        chk("abort_rsp_cleared", {30'd0, timeout, rsp_resp, rsp_data}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        last_rsp_data = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_stray_rsp", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        end
        run_cmd(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b00, 32'h0BAD_F00D);

        // Slave never answers the write response
        b_never = 1'b1; aw_dly = 0; w_dly = 0; b_dly = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_data = 32'h1; cmd_strb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int unsigned k = 1; k <= 22; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
            exp_to = (k >= 16);
`else
            exp_to = 1'b0;
`endif
            chk($sformatf("watchdog_k%0d", k), {61'd0, timeout, bready, rsp_valid},
                {61'd0, exp_to, (k >= 2), 1'b0});
        end
        #2 rst_n = 1'b0;
        #1;
        chk("timeout_cleared_by_reset", {62'd0, timeout, bready}, 64'd0);
        b_never = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        last_rsp_data = '0;
        @(posedge clk); #1;

        // Random commands against the slave model
        for (int n = 0; n < 40; n++) begin
            wr_r    = 1'($urandom_range(0, 1));
            rresp_r = 2'($urandom_range(0, 3));
            run_cmd(wr_r, $urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), rresp_r, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("idle_gap", {62'd0, rsp_valid, cmd_ready}, 64'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
